res_arbiter: RTL and testbench
==============================

Name: res_arbiter

Overview:
- Round-robin arbiter that shares the single result-message generator's 81-bit result channel between N_REQ command-execution units.
- Each requester offers a packed result word: type[80:78], start addr[77:71], end addr[70:64], data[63:0]. The arbiter passes it through unchanged.
- It sits between the execution units and the message generator, and sequences one result at a time onto the generator's RDY_T/RDY_R handshake.
- It tags each forwarded result with the ID of the requester that produced it.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester ID; must be at least clog2(N_REQ).
- DW, 81, result word width.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- REQ_RDY_T  in  N_REQ  per-requester result valid; the requester holds it and its data until accepted
- REQ_DATA  in  N_REQ*DW  packed result words; requester i occupies bits [i*DW +: DW]
- REQ_RDY_R  out  N_REQ  per-requester accept; one-hot, one-cycle pulse
- RES_RDY_T  out  1  result valid towards the generator
- RES_DATA_R  out  DW  registered result word
- RES_RDY_R  in  1  generator ready; the generator holds it high while idle
- RES_ID  out  IDW  requester ID of the word on RES_DATA_R
- BUSY  out  1  high in every state other than IDLE
- ERR  out  1  one-cycle pulse on a protocol abort
- GRANT_CNT  out  16  count of completed transfers; wraps

Behaviour:
- Reset values: REQ_RDY_R=0, RES_RDY_T=0, RES_DATA_R=0, RES_ID=0, ERR=0, GRANT_CNT=0, state=IDLE, pointer LAST=N_REQ-1 (requester 0 wins first).
- A transfer happens on any rising edge where the valid (RDY_T) and ready (RDY_R) of one channel are both high.
- States: IDLE, GRANT, SEND.
- IDLE:
  - If any REQ_RDY_T bit is set, pick the winner W as the first set bit searching LAST+1, LAST+2, ... with wrap at N_REQ.
  - Register W as the grant, drive REQ_RDY_R[W]=1 and go to GRANT.
  - If no bit is set, stay in IDLE.
- GRANT (exactly one cycle; REQ_RDY_R[W]=1 throughout):
  - If REQ_RDY_T[W] is still high: on the edge, capture REQ_DATA[W] into RES_DATA_R and W into RES_ID, set LAST=W, set RES_RDY_T=1, clear REQ_RDY_R and go to SEND.
  - If REQ_RDY_T[W] has dropped (requester withdrew): clear REQ_RDY_R, pulse ERR for one cycle, leave LAST unchanged and return to IDLE. Nothing is sent.
- SEND:
  - Hold RES_RDY_T=1 and keep RES_DATA_R and RES_ID stable until an edge where RES_RDY_R=1.
  - On that edge: set RES_RDY_T=0, increment GRANT_CNT (wraps 16'hFFFF->0) and go to IDLE.
  - RES_RDY_R=0 stalls SEND indefinitely.
- Latency: request seen at edge k -> REQ_RDY_R high in cycle k+1 -> RES_RDY_T high from edge k+2 -> transfer at edge k+3 at the earliest. Minimum 3 cycles per result.
- New requests arriving during GRANT or SEND are only evaluated in IDLE. Requests are never lost, because requesters hold them.
- Fairness: a requester that is continuously requesting is served within N_REQ grants.
- Single requester: it is served back-to-back every 3 cycles.
- RES_DATA_R and RES_ID retain their last value in IDLE. Consumers qualify them with RES_RDY_T.
- RST mid-operation: all outputs and state return to reset values immediately. Any pending REQ_RDY_R or RES_RDY_T is dropped, and no partial transfer is counted.
- Requester IDs >= N_REQ never win. Unused request bits are treated as 0.

Decomposition:
- Shared package res_pkg holds:
  - result field offsets: TYPE_HI=80, TYPE_LO=78, SADDR_HI=77, EADDR_HI=70, DATA_HI=63;
  - DW=81;
  - state encoding: IDLE=0, GRANT=1, SEND=2;
  - result-type codes 3'b001 and 3'b010.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request vector and LAST.
  - Outputs: winner ID and an any-valid flag.
  - Implemented as a rotate, then a fixed priority encoder, then a rotate back.

Test Plan:
1. After reset, only REQ_RDY_T=4'b0100 with data 81'h0_AA55 -> REQ_RDY_R=4'b0100 for 1 cycle; RES_RDY_T rises 2 cycles after the request; RES_DATA_R=81'h0_AA55, RES_ID=2, GRANT_CNT=1 after the transfer.
2. All four requesters held high, RES_RDY_R tied to 1 -> grant order 0,1,2,3,0; one transfer every 3 cycles; GRANT_CNT=5 after 15 cycles.
3. Requester 1 granted, then withdraws REQ_RDY_T during GRANT -> ERR pulses 1 cycle; RES_RDY_T stays 0; GRANT_CNT unchanged; the next winner search still starts at 1.
4. RES_RDY_R held 0 for 20 cycles in SEND -> RES_RDY_T, RES_DATA_R and RES_ID stable and no new REQ_RDY_R; RES_RDY_R=1 -> transfer completes and the arbiter returns to IDLE the next cycle.
5. RST asserted while in SEND -> RES_RDY_T=0, BUSY=0 and LAST=3 immediately; after release with requests 4'b1001, requester 0 wins.
6. GRANT_CNT preloaded via 65535 transfers, then one more -> GRANT_CNT wraps to 0.

Source files
------------

// File: rtl/res_pkg.sv
// Shared definitions for the result-channel arbiter: word layout, FSM encoding and type codes.
package res_pkg;

    localparam int unsigned DW       = 81;
    localparam int unsigned TYPE_HI  = 80;
    localparam int unsigned TYPE_LO  = 78;
    localparam int unsigned SADDR_HI = 77;
    localparam int unsigned EADDR_HI = 70;
    localparam int unsigned DATA_HI  = 63;

    localparam logic [2:0] RTYPE_RESULT = 3'b001;
    localparam logic [2:0] RTYPE_DATA   = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2
    } state_e;

endpackage

// File: rtl/res_arbiter_if.sv
// Result channel between the execution units, the arbiter and the message generator.
interface res_arbiter_if
    import res_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2,
    parameter int unsigned W     = DW
);
    logic [N_REQ-1:0]   REQ_RDY_T;
    logic [N_REQ*W-1:0] REQ_DATA;
    logic [N_REQ-1:0]   REQ_RDY_R;
    logic               RES_RDY_T;
    logic [W-1:0]       RES_DATA_R;
    logic               RES_RDY_R;
    logic [IDW-1:0]     RES_ID;

    modport master (
        input  REQ_RDY_T, REQ_DATA, RES_RDY_R,
        output REQ_RDY_R, RES_RDY_T, RES_DATA_R, RES_ID
    );

    modport slave (
        output REQ_RDY_T, REQ_DATA, RES_RDY_R,
        input  REQ_RDY_R, RES_RDY_T, RES_DATA_R, RES_ID
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate past the last winner, fixed-priority encode, rotate back.
module rr_pick
    import res_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic [IDW-1:0]   win,
    output logic             any
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    int unsigned        start;
    int unsigned        off;

    always_comb begin
        start = (int'(last) + 1) % N_REQ;
        dbl   = {req, req};
        // rot[0] is the requester immediately after the last winner
        rot   = N_REQ'(dbl >> start);
        off   = 0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) off = j;
        end
        any = |req;
        win = IDW'((start + off) % N_REQ);
    end

endmodule

// File: rtl/res_arbiter.sv
// Round-robin arbiter sequencing N_REQ execution-unit results onto the generator's result channel.
module res_arbiter
    import res_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2,
    parameter int unsigned W     = DW
) (
    input  logic                CLK,
    input  logic                RST,
    res_arbiter_if.master       bus,
    output logic                BUSY,
    output logic                ERR,
    output logic [15:0]         GRANT_CNT
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_q, grant_q, res_id_q, win;
    logic [W-1:0]     data_q, granted_word;
    logic [N_REQ-1:0] grant_oh;
    logic             any, err_q, req_hold;
    logic [15:0]      cnt_q;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req  (bus.REQ_RDY_T),
        .last (last_q),
        .win  (win),
        .any  (any)
    );

    assign grant_oh     = N_REQ'(1) << grant_q;
    assign req_hold     = |(bus.REQ_RDY_T & grant_oh);
    assign granted_word = W'(bus.REQ_DATA >> (int'(grant_q) * W));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any) state_d = GRANT;
            GRANT:   state_d = req_hold ? SEND : IDLE;
            SEND:    if (bus.RES_RDY_R) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.REQ_RDY_R = '0;
        bus.RES_RDY_T = 1'b0;
        unique case (state_q)
            GRANT:   bus.REQ_RDY_R = grant_oh;
            SEND:    bus.RES_RDY_T = 1'b1;
            default: ;
        endcase
        BUSY = (state_q != IDLE);
    end

    // A withdrawn grant leaves last_q untouched so the same search order is retried.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q   <= IDW'(N_REQ - 1);
            grant_q  <= '0;
            res_id_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            err_q <= 1'b0;
            if (state_q == IDLE && any) grant_q <= win;
            if (state_q == GRANT) begin
                if (req_hold) begin
                    data_q   <= granted_word;
                    res_id_q <= grant_q;
                    last_q   <= grant_q;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == SEND && bus.RES_RDY_R) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.RES_DATA_R = data_q;
    assign bus.RES_ID     = res_id_q;
    assign ERR            = err_q;
    assign GRANT_CNT      = cnt_q;

endmodule

// File: tb/tb_res_arbiter.sv
// Directed bench for res_arbiter: grant order, latency, withdrawal, stall, reset and counter wrap.
module tb_res_arbiter;
    import res_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        BUSY, ERR;
    logic [15:0] GRANT_CNT;
    int          checks   = 0;
    int          failures = 0;
    logic [DW-1:0] word [N];

    res_arbiter_if #(.N_REQ(N), .IDW(IDW), .W(DW)) bus ();

    res_arbiter #(
        .N_REQ (N),
        .IDW   (IDW),
        .W     (DW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus.master),
        .BUSY      (BUSY),
        .ERR       (ERR),
        .GRANT_CNT (GRANT_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.REQ_RDY_T = '0;
        step();
        RST = 1'b0;
    endtask

    task automatic load_words();
        bus.REQ_DATA = {word[3], word[2], word[1], word[0]};
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            word[i] = {3'b001, 7'(i), 7'(i + 16), 64'hC0DE_0000_0000_0000 | 64'(i)};
        end
        bus.REQ_RDY_T = '0;
        bus.RES_RDY_R = 1'b1;
        load_words();
        @(negedge CLK);
        RST = 1'b0;

        check("rst_req_rdy_r", 128'(bus.REQ_RDY_R), 128'(4'b0000));
        check("rst_res_rdy_t", 128'(bus.RES_RDY_T), 128'(1'b0));
        check("rst_res_data",  128'(bus.RES_DATA_R), 128'(0));
        check("rst_res_id",    128'(bus.RES_ID), 128'(0));
        check("rst_err",       128'(ERR), 128'(1'b0));
        check("rst_cnt",       128'(GRANT_CNT), 128'(0));
        check("rst_busy",      128'(BUSY), 128'(1'b0));

        // 1: single request from requester 2
        bus.REQ_DATA = {word[3], 81'h0_AA55, word[1], word[0]};
        bus.REQ_RDY_T = 4'b0100;
        step();
        check("t1_grant",       128'(bus.REQ_RDY_R), 128'(4'b0100));
        check("t1_no_valid",    128'(bus.RES_RDY_T), 128'(1'b0));
        step();
        check("t1_accept_drop", 128'(bus.REQ_RDY_R), 128'(4'b0000));
        check("t1_valid",       128'(bus.RES_RDY_T), 128'(1'b1));
        check("t1_data",        128'(bus.RES_DATA_R), 128'(81'h0_AA55));
        check("t1_id",          128'(bus.RES_ID), 128'(2));
        bus.REQ_RDY_T = '0;
        step();
        check("t1_valid_low",   128'(bus.RES_RDY_T), 128'(1'b0));
        check("t1_cnt",         128'(GRANT_CNT), 128'(1));
        check("t1_idle",        128'(BUSY), 128'(1'b0));
        check("t1_data_kept",   128'(bus.RES_DATA_R), 128'(81'h0_AA55));

        // 2: all four requesting, generator always ready
        do_reset();
        load_words();
        bus.REQ_RDY_T = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            check("t2_grant", 128'(bus.REQ_RDY_R), 128'(4'b0001 << (g % 4)));
            step();
            check("t2_id",    128'(bus.RES_ID), 128'(g % 4));
            check("t2_data",  128'(bus.RES_DATA_R), 128'(word[g % 4]));
            step();
            check("t2_cnt",   128'(GRANT_CNT), 128'(g + 1));
        end
        bus.REQ_RDY_T = '0;

        // 3: requester 1 withdraws during GRANT after requester 0 was served
        do_reset();
        bus.REQ_RDY_T = 4'b0011;
        step();
        check("t3_grant0", 128'(bus.REQ_RDY_R), 128'(4'b0001));
        step();
        bus.REQ_RDY_T = 4'b0010;
        step();
        check("t3_cnt1",   128'(GRANT_CNT), 128'(1));
        step();
        check("t3_grant1", 128'(bus.REQ_RDY_R), 128'(4'b0010));
        bus.REQ_RDY_T = 4'b0000;
        step();
        check("t3_err",       128'(ERR), 128'(1'b1));
        check("t3_no_valid",  128'(bus.RES_RDY_T), 128'(1'b0));
        check("t3_idle",      128'(BUSY), 128'(1'b0));
        check("t3_no_grant",  128'(bus.REQ_RDY_R), 128'(4'b0000));
        step();
        check("t3_err_pulse", 128'(ERR), 128'(1'b0));
        check("t3_cnt_same",  128'(GRANT_CNT), 128'(1));
        bus.REQ_RDY_T = 4'b0011;
        step();
        check("t3_regrant1",  128'(bus.REQ_RDY_R), 128'(4'b0010));
        bus.REQ_RDY_T = '0;

        // 4: generator stalls for 20 cycles
        do_reset();
        bus.RES_RDY_R = 1'b0;
        bus.REQ_RDY_T = 4'b0001;
        step();
        check("t4_grant", 128'(bus.REQ_RDY_R), 128'(4'b0001));
        step();
        bus.REQ_RDY_T = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            step();
            check("t4_hold_valid", 128'(bus.RES_RDY_T), 128'(1'b1));
            check("t4_hold_id",    128'(bus.RES_ID), 128'(0));
            check("t4_hold_data",  128'(bus.RES_DATA_R), 128'(word[0]));
            check("t4_no_grant",   128'(bus.REQ_RDY_R), 128'(4'b0000));
        end
        bus.RES_RDY_R = 1'b1;
        step();
        check("t4_done_valid", 128'(bus.RES_RDY_T), 128'(1'b0));
        check("t4_done_idle",  128'(BUSY), 128'(1'b0));
        check("t4_done_cnt",   128'(GRANT_CNT), 128'(1));
        bus.REQ_RDY_T = '0;

        // 5: reset while in SEND restores the pointer
        do_reset();
        bus.RES_RDY_R = 1'b0;
        bus.REQ_RDY_T = 4'b0010;
        step(2);
        check("t5_in_send", 128'(bus.RES_RDY_T), 128'(1'b1));
        RST = 1'b1;
        #1;
        check("t5_rst_valid", 128'(bus.RES_RDY_T), 128'(1'b0));
        check("t5_rst_busy",  128'(BUSY), 128'(1'b0));
        check("t5_rst_id",    128'(bus.RES_ID), 128'(0));
        check("t5_rst_data",  128'(bus.RES_DATA_R), 128'(0));
        check("t5_rst_cnt",   128'(GRANT_CNT), 128'(0));
        bus.REQ_RDY_T = 4'b1001;
        bus.RES_RDY_R = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        step();
        check("t5_winner0", 128'(bus.REQ_RDY_R), 128'(4'b0001));
        bus.REQ_RDY_T = '0;

        // 6: counter wrap from a preloaded value, single requester back-to-back
        do_reset();
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        bus.REQ_RDY_T = 4'b0001;
        step();
        check("t6_grant_a", 128'(bus.REQ_RDY_R), 128'(4'b0001));
        step(2);
        check("t6_cnt_ffff", 128'(GRANT_CNT), 128'(16'hFFFF));
        step();
        check("t6_grant_b", 128'(bus.REQ_RDY_R), 128'(4'b0001));
        step(2);
        check("t6_cnt_wrap", 128'(GRANT_CNT), 128'(16'h0000));
        bus.REQ_RDY_T = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
